binary_frame_buffer: RTL and testbench

//  Upstream stage of the 3x3 median window filter. Thresholds an 8-bit grayscale raster stream to 1 bit/pixel.

---
 rtl/binary_frame_buffer.sv | 166 ++++++++++++++++
 tb/tb_binary_frame_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/binary_frame_buffer.sv
// Thresholds a grayscale raster stream to 1 bit/pixel into a ping-pong bit buffer.
// It also sequences the downstream median filter's init/start handshake.
module binary_frame_buffer #(
    parameter int IMG_W = 240,
    parameter int IMG_H = 180,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    input  logic [PIX_W-1:0] threshold,
    input  logic [7:0]       rd_x,
    input  logic [7:0]       rd_y,
    output logic             rd_data,
    input  logic             filt_done,
    output logic             filt_init,
    output logic             filt_start,
    output logic             frame_busy,
    output logic [7:0]       drop_cnt,
    output logic [7:0]       short_cnt
);
    // state      | meaning
    // W_WAIT_SOF | write bank empty, waiting for a frame start
    // W_FILL     | storing pixels in raster order
    // W_HOLD     | write bank full, waiting for the reader to take it
    // R_IDLE     | no frame owned by the filter
    // R_INIT     | one-cycle filter clear
    // R_RUN      | filter running until it reports done
    // R_DRAIN    | one extra run cycle for the final window

    localparam int BANK_SZ = IMG_W * IMG_H;
    localparam int AW      = $clog2(2 * BANK_SZ);
    localparam int XW      = $clog2(IMG_W);
    localparam int YW      = $clog2(IMG_H);

    typedef enum logic [1:0] {W_WAIT_SOF, W_FILL, W_HOLD} wrState_t;
    typedef enum logic [1:0] {R_IDLE, R_INIT, R_RUN, R_DRAIN} rdState_t;

    wrState_t wrState, wrNext;
    rdState_t rdState, rdNext;

    logic          wrBank, rdBank, full;
    logic [XW-1:0] xCnt, xNext, wrX;
    logic [YW-1:0] yCnt, yNext, wrY;
    logic          wrEn, setFull, swap, incShort, incDrop;
    logic [AW-1:0] wrAddr, rdAddr;
    logic          inRange;

    logic mem [2*BANK_SZ];

    always_comb begin
        wrNext   = wrState;
        wrEn     = 1'b0;
        wrX      = xCnt;
        wrY      = yCnt;
        xNext    = xCnt;
        yNext    = yCnt;
        setFull  = 1'b0;
        incShort = 1'b0;
        incDrop  = 1'b0;
        case (wrState)
            W_WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    wrEn   = 1'b1;
                    wrX    = '0;
                    wrY    = '0;
                    xNext  = XW'(1);
                    yNext  = '0;
                    wrNext = W_FILL;
                end
            end
            W_FILL: begin
                if (pix_valid) begin
                    wrEn = 1'b1;
                    if (pix_sof) begin
                        // early frame start: restart the fill from the origin
                        incShort = 1'b1;
                        wrX      = '0;
                        wrY      = '0;
                        xNext    = XW'(1);
                        yNext    = '0;
                    end else if (xCnt == XW'(IMG_W - 1)) begin
                        xNext = '0;
                        if (yCnt == YW'(IMG_H - 1)) begin
                            yNext   = '0;
                            setFull = 1'b1;
                            wrNext  = W_HOLD;
                        end else begin
                            yNext = yCnt + YW'(1);
                        end
                    end else begin
                        xNext = xCnt + XW'(1);
                    end
                end
            end
            W_HOLD: begin
                if (pix_valid && pix_sof) incDrop = 1'b1;
                if (swap) wrNext = W_WAIT_SOF;
            end
            default: wrNext = W_WAIT_SOF;
        endcase
    end

    always_comb begin
        rdNext = rdState;
        swap   = 1'b0;
        case (rdState)
            R_IDLE: begin
                if (full) begin
                    swap   = 1'b1;
                    rdNext = R_INIT;
                end
            end
            R_INIT:  rdNext = R_RUN;
            R_RUN:   if (filt_done) rdNext = R_DRAIN;
            R_DRAIN: rdNext = R_IDLE;
            default: rdNext = R_IDLE;
        endcase
    end

    assign filt_init  = (rdState == R_INIT);
    assign filt_start = (rdState == R_RUN) || (rdState == R_DRAIN);
    assign frame_busy = (rdState != R_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrState   <= W_WAIT_SOF;
            rdState   <= R_IDLE;
            wrBank    <= 1'b0;
            rdBank    <= 1'b1;
            full      <= 1'b0;
            xCnt      <= '0;
            yCnt      <= '0;
            drop_cnt  <= 8'd0;
            short_cnt <= 8'd0;
        end else begin
            wrState <= wrNext;
            rdState <= rdNext;
            xCnt    <= xNext;
            yCnt    <= yNext;
            if (swap) begin
                rdBank <= wrBank;
                wrBank <= ~wrBank;
                full   <= 1'b0;
            end else if (setFull) begin
                full <= 1'b1;
            end
            if (incDrop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (incShort && short_cnt != 8'hFF) short_cnt <= short_cnt + 8'd1;
        end
    end

    assign wrAddr = AW'(wrBank) * AW'(BANK_SZ) + AW'(wrY) * AW'(IMG_W) + AW'(wrX);
    assign rdAddr = AW'(rdBank) * AW'(BANK_SZ) + AW'(rd_y) * AW'(IMG_W) + AW'(rd_x);

    // bank storage has no reset; contents are undefined until written
    always_ff @(posedge clk) begin
        if (wrEn && !reset) mem[wrAddr] <= (pix_data >= threshold);
    end

    assign inRange = (int'(rd_x) < IMG_W) && (int'(rd_y) < IMG_H);
    assign rd_data = inRange ? mem[rdAddr] : 1'b0;

endmodule

// File: tb/tb_binary_frame_buffer.sv
// Directed bench for binary_frame_buffer on a reduced 20x6 raster.
// Frames use pixel = (7x + 13y + seed) & 255 so each frame has a distinct bit pattern.
module tb_binary_frame_buffer;
    localparam int W  = 20;
    localparam int H  = 6;
    localparam int NP = W * H;

    logic       clk = 1'b0;
    logic       reset, pix_valid, pix_sof, filt_done;
    logic       rd_data, filt_init, filt_start, frame_busy;
    logic [7:0] pix_data, threshold, rd_x, rd_y, drop_cnt, short_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    binary_frame_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk(clk), .reset(reset),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .threshold(threshold),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .filt_done(filt_done), .filt_init(filt_init), .filt_start(filt_start),
        .frame_busy(frame_busy), .drop_cnt(drop_cnt), .short_cnt(short_cnt)
    );

    function automatic logic [7:0] pixVal(input int seed, input int x, input int y);
        return 8'((x * 7 + y * 13 + seed) & 255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sendFrame(input int seed, input int npix, input logic [7:0] thr);
        threshold = thr;
        for (int i = 0; i < npix; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_data  = pixVal(seed, i % W, i / W);
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input int seed, input logic [7:0] thr);
        int errs = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_x = 8'(x);
                rd_y = 8'(y);
                #1;
                if (rd_data !== (pixVal(seed, x, y) >= thr)) errs++;
            end
        end
        rd_x = 8'd0;
        rd_y = 8'd0;
        check(tag, 32'(errs), 0);
        tick();
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'd0;
        threshold = 8'd0; rd_x = 8'd0; rd_y = 8'd0; filt_done = 1'b0;
        tick(); tick();
        check("rst_init",  32'(filt_init), 0);
        check("rst_start", 32'(filt_start), 0);
        check("rst_busy",  32'(frame_busy), 0);
        check("rst_drop",  32'(drop_cnt), 0);
        check("rst_short", 32'(short_cnt), 0);
        reset = 1'b0;
        tick();

        // pixels without a frame start are ignored
        for (int i = 0; i < 30; i++) begin
            pix_valid = 1'b1; pix_data = 8'hFF; tick();
        end
        pix_valid = 1'b0;
        tick();
        check("nosof_busy", 32'(frame_busy), 0);

        // frame A into bank 0
        sendFrame(120, NP, 8'd128);
        check("A_init_early", 32'(filt_init), 0);
        check("nosof_short",  32'(short_cnt), 0);
        tick();
        check("A_init",  32'(filt_init), 1);
        check("A_start_during_init", 32'(filt_start), 0);
        check("A_busy",  32'(frame_busy), 1);
        tick();
        check("A_init_drop", 32'(filt_init), 0);
        check("A_start", 32'(filt_start), 1);
        checkFrame("A_data", 120, 8'd128);

        // frame B arrives while the filter is busy: held, not dropped
        sendFrame(200, NP, 8'd128);
        check("B_drop",      32'(drop_cnt), 0);
        check("B_busy",      32'(frame_busy), 1);
        check("B_start_run", 32'(filt_start), 1);
        check("B_no_init",   32'(filt_init), 0);

        // out-of-range reads; unguarded these would alias A(0,1)=1 and B(0,0)=1
        rd_x = 8'(W); rd_y = 8'd0; #1;
        check("rdx_oob", 32'(rd_data), 0);
        rd_x = 8'd0; rd_y = 8'(H); #1;
        check("rdy_oob", 32'(rd_data), 0);
        rd_x = 8'd255; rd_y = 8'd255; #1;
        check("rdxy_oob", 32'(rd_data), 0);
        rd_x = 8'd0; rd_y = 8'd0;
        tick();

        // frame C while B is held: dropped
        sendFrame(30, NP, 8'd128);
        check("C_drop", 32'(drop_cnt), 1);
        checkFrame("A_after_C", 120, 8'd128);

        // filter done on A: drain, idle, then B swaps in
        filt_done = 1'b1;
        tick();
        filt_done = 1'b0;
        check("A_drain_start", 32'(filt_start), 1);
        check("A_drain_busy",  32'(frame_busy), 1);
        tick();
        check("A_idle_start", 32'(filt_start), 0);
        check("A_idle_busy",  32'(frame_busy), 0);
        check("A_idle_init",  32'(filt_init), 0);
        tick();
        check("B_init",  32'(filt_init), 1);
        tick();
        check("B_start", 32'(filt_start), 1);
        checkFrame("B_data", 200, 8'd128);
        check("B_drop_final", 32'(drop_cnt), 1);

        filt_done = 1'b1;
        tick();
        filt_done = 1'b0;
        tick();
        check("B_idle_busy", 32'(frame_busy), 0);

        // truncated frame D then full frame E with a different threshold
        sendFrame(10, 50, 8'd128);
        check("D_no_busy", 32'(frame_busy), 0);
        sendFrame(77, NP, 8'd100);
        check("E_short",      32'(short_cnt), 1);
        check("E_init_early", 32'(filt_init), 0);
        tick();
        check("E_init", 32'(filt_init), 1);
        tick();
        check("E_init_drop", 32'(filt_init), 0);
        check("E_start",     32'(filt_start), 1);
        checkFrame("E_data", 77, 8'd100);

        // reset during filter run and mid-fill
        sendFrame(90, 30, 8'd128);
        check("F_start_before_rst", 32'(filt_start), 1);
        reset = 1'b1;
        tick();
        check("rst2_start", 32'(filt_start), 0);
        check("rst2_init",  32'(filt_init), 0);
        check("rst2_busy",  32'(frame_busy), 0);
        check("rst2_drop",  32'(drop_cnt), 0);
        check("rst2_short", 32'(short_cnt), 0);
        reset = 1'b0;
        tick();

        sendFrame(60, NP, 8'd128);
        check("G_short",      32'(short_cnt), 0);
        check("G_init_early", 32'(filt_init), 0);
        tick();
        check("G_init", 32'(filt_init), 1);
        tick();
        check("G_start", 32'(filt_start), 1);
        checkFrame("G_data", 60, 8'd128);
        filt_done = 1'b1;
        tick();
        filt_done = 1'b0;
        check("G_drain_start", 32'(filt_start), 1);
        tick();
        check("G_idle_start", 32'(filt_start), 0);
        check("G_idle_busy",  32'(frame_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
